// File: rtl/eth_pkg.sv
// Shared Ethernet types: FIFO pointers/status/commands, AXIS byte-stream
// structs, the UDP transmit header and the transmit-sequencer state/error enums.
package eth_pkg;

   typedef logic [15:0] ptr_t;
   typedef logic [15:0] udp_length_t;

   typedef struct packed {
      ptr_t rd_ptr;
      ptr_t wr_ptr;
      logic empty;
      logic full;
      logic done;
   } s_fifo_st_t;

   typedef struct packed {
      logic        start;
      udp_length_t length;
      logic        clear;
   } s_fifo_cmd_t;

   typedef struct packed {
      logic [7:0] tdata;
      logic       tvalid;
      logic       tlast;
   } s_axis_mosi_t;

   typedef struct packed {
      logic tready;
   } s_axis_miso_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] ip_dst;
      logic [15:0] src_port;
      logic [15:0] dst_port;
      udp_length_t length;
   } s_udp_tx_hdr_t;

   typedef enum logic [1:0] {
      ERR_NONE      = 2'd0,
      ERR_ZERO_LEN  = 2'd1,
      ERR_UNDERFLOW = 2'd2,
      ERR_TIMEOUT   = 2'd3
   } tx_err_t;

   typedef enum logic [1:0] {
      TX_IDLE    = 2'd0,
      TX_HDR     = 2'd1,
      TX_PAYLOAD = 2'd2,
      TX_DONE    = 2'd3
   } fsm_tx_seq_t;

   localparam int ETH_TX_HDR_TIMEOUT_DEF = 4096;

endpackage

// File: rtl/eth_udp_tx_seq.sv
// UDP transmit sequencer (clk_eth domain): validates a send request against
// the OutFIFO fill level, presents the UDP header, starts the OutFIFO and
// forwards its byte stream to the UDP stack.
// Optional feature macro: ETH_TX_HDR_TIMEOUT_EN (abort a header handshake
// that takes longer than HDR_TIMEOUT cycles).
module eth_udp_tx_seq import eth_pkg::*; #(
   parameter int HDR_TIMEOUT = ETH_TX_HDR_TIMEOUT_DEF
) (
   input  logic          clk_eth,
   input  logic          rst_eth,
   input  logic          send_i,
   input  udp_length_t   length_i,
   input  logic [31:0]   dst_ip_i,
   input  logic [15:0]   src_port_i,
   input  logic [15:0]   dst_port_i,
   input  logic          clear_i,
   input  s_fifo_st_t    fifo_st_i,
   output s_fifo_cmd_t   fifo_cmd_o,
   input  s_axis_mosi_t  axis_fifo_mosi_i,
   output s_axis_miso_t  axis_fifo_miso_o,
   output s_axis_mosi_t  axis_udp_mosi_o,
   input  s_axis_miso_t  axis_udp_miso_i,
   output s_udp_tx_hdr_t udp_hdr_o,
   input  logic          udp_hdr_ready_i,
   output logic          busy_o,
   output logic          tx_done_o,
   output logic          tx_err_o,
   output tx_err_t       err_code_o
);

   fsm_tx_seq_t state, state_nxt;

   udp_length_t len_q;
   logic [31:0] ip_q;
   logic [15:0] src_q;
   logic [15:0] dst_q;

   ptr_t        avail;
   logic        accept;
   logic        err_set;
   tx_err_t     err_nxt;
   logic        tx_err_q;
   tx_err_t     err_code_q;
   udp_length_t beat_cnt;
   logic        beat_fire;
   logic        hdr_timeout;

   // Modulo subtraction keeps the fill level correct across pointer wrap
   assign avail     = fifo_st_i.wr_ptr - fifo_st_i.rd_ptr;
   assign beat_fire = (state == TX_PAYLOAD) && axis_fifo_mosi_i.tvalid && axis_udp_miso_i.tready;

`ifdef ETH_TX_HDR_TIMEOUT_EN
   logic [31:0] hdr_cnt;
   logic        unused_sigs;

   // Count cycles spent waiting for the stack to take the header
   always_ff @(posedge clk_eth or negedge rst_eth) begin
      if (!rst_eth)              hdr_cnt <= '0;
      else if (state == TX_HDR)  hdr_cnt <= hdr_cnt + 32'd1;
      else                       hdr_cnt <= '0;
   end

   assign hdr_timeout = (state == TX_HDR) && !udp_hdr_ready_i &&
                        (hdr_cnt == 32'(HDR_TIMEOUT - 1));
   assign unused_sigs = ^{fifo_st_i.empty, fifo_st_i.full};
`else
   logic unused_sigs;

   assign hdr_timeout = 1'b0;
   assign unused_sigs = ^{fifo_st_i.empty, fifo_st_i.full, 32'(HDR_TIMEOUT)};
`endif

   // State register
   always_ff @(posedge clk_eth or negedge rst_eth) begin
      if (!rst_eth) state <= TX_IDLE;
      else          state <= state_nxt;
   end

   // Next state, request validation and all datapath outputs
   always_comb begin
      state_nxt        = state;
      accept           = 1'b0;
      err_set          = 1'b0;
      err_nxt          = ERR_NONE;
      fifo_cmd_o       = '0;
      udp_hdr_o        = '0;
      axis_udp_mosi_o  = '0;
      axis_fifo_miso_o = '0;
      busy_o           = (state != TX_IDLE);
      tx_done_o        = 1'b0;
      case (state)
         TX_IDLE: begin
            if (send_i) begin
               if (length_i == '0) begin
                  err_set = 1'b1;
                  err_nxt = ERR_ZERO_LEN;
               end else if (length_i > avail) begin
                  err_set = 1'b1;
                  err_nxt = ERR_UNDERFLOW;
               end else begin
                  accept    = 1'b1;
                  state_nxt = TX_HDR;
               end
            end else begin
               fifo_cmd_o.clear = clear_i;
            end
         end
         TX_HDR: begin
            udp_hdr_o.valid    = 1'b1;
            udp_hdr_o.ip_dst   = ip_q;
            udp_hdr_o.src_port = src_q;
            udp_hdr_o.dst_port = dst_q;
            udp_hdr_o.length   = len_q;
            if (udp_hdr_ready_i) begin
               state_nxt = TX_PAYLOAD;
            end else if (hdr_timeout) begin
               err_set   = 1'b1;
               err_nxt   = ERR_TIMEOUT;
               state_nxt = TX_IDLE;
            end
         end
         TX_PAYLOAD: begin
            fifo_cmd_o.start        = 1'b1;
            fifo_cmd_o.length       = len_q;
            axis_udp_mosi_o         = axis_fifo_mosi_i;
            axis_fifo_miso_o.tready = axis_udp_miso_i.tready;
            if (fifo_st_i.done) state_nxt = TX_DONE;
         end
         TX_DONE: begin
            tx_done_o = 1'b1;
            state_nxt = TX_IDLE;
         end
         default: state_nxt = TX_IDLE;
      endcase
   end

   // Capture the packet parameters when a send is accepted
   always_ff @(posedge clk_eth or negedge rst_eth) begin
      if (!rst_eth) begin
         len_q <= '0;
         ip_q  <= '0;
         src_q <= '0;
         dst_q <= '0;
      end else if (accept) begin
         len_q <= length_i;
         ip_q  <= dst_ip_i;
         src_q <= src_port_i;
         dst_q <= dst_port_i;
      end
   end

   // Error pulse lands one cycle after its cause; the code is held until the next error
   always_ff @(posedge clk_eth or negedge rst_eth) begin
      if (!rst_eth) begin
         tx_err_q   <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         tx_err_q <= err_set;
         if (err_set) err_code_q <= err_nxt;
      end
   end

   assign tx_err_o   = tx_err_q;
   assign err_code_o = err_code_q;

   // Count accepted payload beats; restarts for every packet
   always_ff @(posedge clk_eth or negedge rst_eth) begin
      if (!rst_eth)                  beat_cnt <= '0;
      else if (state != TX_PAYLOAD)  beat_cnt <= '0;
      else if (beat_fire)            beat_cnt <= beat_cnt + 16'd1;
   end

   // The OutFIFO must mark exactly the length-th beat as last
   assert property (@(posedge clk_eth) disable iff (!rst_eth)
      (beat_fire && axis_fifo_mosi_i.tlast) |-> (beat_cnt == len_q - 16'd1));

endmodule
